// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and widths for the boot memory controller
package mem_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 12;
  localparam int CPU_ADDR_W = 16;

endpackage

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - byte-wide RAM, one write port and one registered read port
module sp_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // No reset: contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/boot_mem_ctrl.sv
// rtl/boot_mem_ctrl.sv - program RAM with byte-stream boot loader and core reset control
// Optional LOAD_CHECKSUM_EN adds load_sum, the modulo-256 sum of accepted bytes.
module boot_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LOAD_BASE = 0,
  parameter int BOOT_HOLD = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CPU_ADDR_W-1:0] cpu_addr,
  output logic [7:0]            cpu_din,
  output logic                  cpu_reset,
  input  logic                  load_start,
  input  logic [15:0]           load_len,
  input  logic [7:0]            load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic [15:0]           bytes_loaded
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [7:0]            load_sum
`endif
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(LOAD_BASE);
  localparam state_t            ST_RESET = (BOOT_HOLD != 0) ? ST_HOLD : ST_RUN;

  state_t            state;
  logic [15:0]       len;
  logic [ADDR_W-1:0] wr_ptr;
  logic              run_q;
  logic [7:0]        ram_rdata;
  logic              xfer;
  logic              unused_addr_hi;

  assign xfer           = load_valid && load_ready;
  assign unused_addr_hi = ^cpu_addr[CPU_ADDR_W-1:ADDR_W];

  sp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr (wr_ptr),
    .wdata (load_data),
    .raddr (cpu_addr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // run_q marks that the RAM read was taken in ST_RUN; otherwise the core sees 0.
  assign cpu_din = run_q ? ram_rdata : 8'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RESET;
      cpu_reset    <= (BOOT_HOLD != 0);
      load_ready   <= 1'b0;
      load_busy    <= 1'b0;
      load_done    <= 1'b0;
      bytes_loaded <= 16'd0;
      len          <= 16'd0;
      wr_ptr       <= BASE;
      run_q        <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      load_sum     <= 8'd0;
`endif
    end else begin
      load_done <= 1'b0;
      run_q     <= (state == ST_RUN);
      case (state)
        ST_HOLD, ST_RUN: begin
          if (load_start) begin
            len          <= load_len;
            bytes_loaded <= 16'd0;
            wr_ptr       <= BASE;
            cpu_reset    <= 1'b1;
`ifdef LOAD_CHECKSUM_EN
            load_sum     <= 8'd0;
`endif
            if (load_len == 16'd0) begin
              state     <= ST_RELEASE;
              load_done <= 1'b1;
            end else begin
              state      <= ST_LOAD;
              load_ready <= 1'b1;
              load_busy  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            wr_ptr       <= wr_ptr + ADDR_W'(1);
            bytes_loaded <= bytes_loaded + 16'd1;
`ifdef LOAD_CHECKSUM_EN
            load_sum     <= load_sum + load_data;
`endif
            if (bytes_loaded + 16'd1 == len) begin
              state      <= ST_RELEASE;
              load_done  <= 1'b1;
              load_ready <= 1'b0;
              load_busy  <= 1'b0;
            end
          end
        end
        ST_RELEASE: begin
          state     <= ST_RUN;
          cpu_reset <= 1'b0;
        end
        default: state <= ST_RESET;
      endcase
    end
  end

endmodule
